// File: rtl/text_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_write_ctrl
// Purpose  : Write-port scheduler for the 80x30 text tile RAM. It arbitrates
//            between a UART byte stream, button edit pulses and an internal
//            clear-screen sequencer. It owns the text cursor and issues one
//            registered RAM write per accepted event.
// Ports    : clk_i        system clock
//            rst_ni       asynchronous active-low reset
//            btn_pulse_i  [0] write sw char, [1] cursor right, [2] clear
//            sw_i         character code for a btn_pulse_i[0] write
//            rx_data_i    UART byte; rx_valid_i / rx_ready_o handshake
//            we_o, waddr_o ({y,x}), wdata_o   registered RAM write port
//            cur_x_o, cur_y_o                  registered cursor position
//            busy_o       high while the clear sequencer runs
// Revision : 1.0  initial release
// ============================================================================
module text_write_ctrl #(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 30,
  parameter logic [6:0] CLR_CHAR = 7'h00
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  btn_pulse_i,
  input  logic [6:0]  sw_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        we_o,
  output logic [11:0] waddr_o,
  output logic [6:0]  wdata_o,
  output logic [6:0]  cur_x_o,
  output logic [4:0]  cur_y_o,
  output logic        busy_o
);

  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t      state_q;
  logic [6:0]  cur_x_q;
  logic [4:0]  cur_y_q;
  logic [6:0]  clr_x_q;   // next address the clear sequencer will write
  logic [4:0]  clr_y_q;
  logic        we_q;
  logic [11:0] waddr_q;
  logic [6:0]  wdata_q;
  logic        busy_q;

  // Combinational cursor neighbours
  logic [6:0] adv_x, ret_x, clr_nx;
  logic [4:0] adv_y, ret_y, clr_ny, lf_y;
  logic       rx_accept;

  always_comb begin
    // Advance one position, row-major, wrapping the whole screen
    adv_x = cur_x_q + 7'd1;
    adv_y = cur_y_q;
    if (cur_x_q == LAST_X) begin
      adv_x = 7'd0;
      adv_y = (cur_y_q == LAST_Y) ? 5'd0 : cur_y_q + 5'd1;
    end

    // Line feed: row only
    lf_y = (cur_y_q == LAST_Y) ? 5'd0 : cur_y_q + 5'd1;

    // Retreat one position for backspace, wrapping (0,0) to the last cell
    ret_x = cur_x_q - 7'd1;
    ret_y = cur_y_q;
    if (cur_x_q == 7'd0) begin
      ret_x = LAST_X;
      ret_y = (cur_y_q == 5'd0) ? LAST_Y : cur_y_q - 5'd1;
    end

    // Clear sequencer step; wraps to (0,0) after the last valid address,
    // which is how the sequencer recognises that it is finished
    clr_nx = clr_x_q + 7'd1;
    clr_ny = clr_y_q;
    if (clr_x_q == LAST_X) begin
      clr_nx = 7'd0;
      clr_ny = (clr_y_q == LAST_Y) ? 5'd0 : clr_y_q + 5'd1;
    end
  end

  // A clear request in the same cycle blocks the UART byte so it stays pending
  assign rx_ready_o = (state_q == S_IDLE) && !btn_pulse_i[2];
  assign rx_accept  = rx_valid_i && rx_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cur_x_q <= 7'd0;
      cur_y_q <= 5'd0;
      clr_x_q <= 7'd0;
      clr_y_q <= 5'd0;
      we_q    <= 1'b0;
      waddr_q <= 12'd0;
      wdata_q <= 7'd0;
      busy_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (btn_pulse_i[2]) begin
            // First clear write is issued right away at (0,0)
            state_q <= S_CLEAR;
            busy_q  <= 1'b1;
            cur_x_q <= 7'd0;
            cur_y_q <= 5'd0;
            we_q    <= 1'b1;
            waddr_q <= 12'd0;
            wdata_q <= CLR_CHAR;
            clr_x_q <= 7'd1;
            clr_y_q <= 5'd0;
          end else if (rx_accept) begin
            case (rx_data_i)
              CH_CR: cur_x_q <= 7'd0;
              CH_LF: cur_y_q <= lf_y;
              CH_BS: begin
                cur_x_q <= ret_x;
                cur_y_q <= ret_y;
                we_q    <= 1'b1;
                waddr_q <= {ret_y, ret_x};
                wdata_q <= CLR_CHAR;
              end
              default: begin
                we_q    <= 1'b1;
                waddr_q <= {cur_y_q, cur_x_q};
                wdata_q <= rx_data_i[6:0];
                cur_x_q <= adv_x;
                cur_y_q <= adv_y;
              end
            endcase
          end else if (btn_pulse_i[0]) begin
            we_q    <= 1'b1;
            waddr_q <= {cur_y_q, cur_x_q};
            wdata_q <= sw_i;
            cur_x_q <= adv_x;
            cur_y_q <= adv_y;
          end else if (btn_pulse_i[1]) begin
            cur_x_q <= adv_x;
            cur_y_q <= adv_y;
          end
        end

        S_CLEAR: begin
          if (clr_x_q == 7'd0 && clr_y_q == 5'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            we_q    <= 1'b1;
            waddr_q <= {clr_y_q, clr_x_q};
            wdata_q <= CLR_CHAR;
            clr_x_q <= clr_nx;
            clr_y_q <= clr_ny;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign cur_x_o = cur_x_q;
  assign cur_y_o = cur_y_q;
  assign busy_o  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_text_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_write_ctrl
// Purpose  : Self-checking bench for text_write_ctrl: a vector table for the
//            single-cycle events plus hand-written sequences for the screen
//            wraps, the clear sequencer and reset during a clear.
// Revision : 1.0  initial release
// ============================================================================
module tb_text_write_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  btn_pulse;
  logic [6:0]  sw;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [11:0] waddr;
  logic [6:0]  wdata;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  text_write_ctrl #(.COLS(80), .ROWS(30), .CLR_CHAR(7'h00)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .btn_pulse_i (btn_pulse),
    .sw_i        (sw),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .we_o        (we),
    .waddr_o     (waddr),
    .wdata_o     (wdata),
    .cur_x_o     (cur_x),
    .cur_y_o     (cur_y),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  btn;
    logic [6:0]  sw;
    logic [7:0]  rxd;
    logic        rxv;
    logic        we;
    logic [11:0] addr;
    logic [6:0]  data;
    logic [6:0]  x;
    logic [4:0]  y;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] b, input logic [6:0] s, input logic [7:0] d, input logic v);
    btn_pulse = b;
    sw        = s;
    rx_data   = d;
    rx_valid  = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One event cycle: drive, clock, then compare the registered outputs
  task automatic ev(input string name, input logic [2:0] b, input logic [7:0] d, input logic v,
                    input logic e_we, input logic [11:0] e_addr, input logic [6:0] e_data,
                    input logic [6:0] e_x, input logic [4:0] e_y);
    drive(b, 7'h00, d, v);
    step();
    drive(3'b000, 7'h00, 8'h00, 1'b0);
    check({name, " we"}, 32'(we), 32'(e_we));
    if (e_we) begin
      check({name, " waddr"}, 32'(waddr), 32'(e_addr));
      check({name, " wdata"}, 32'(wdata), 32'(e_data));
    end
    check({name, " cur_x"}, 32'(cur_x), 32'(e_x));
    check({name, " cur_y"}, 32'(cur_y), 32'(e_y));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(3'b000, 7'h00, 8'h00, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int ex, ey, bad_we, bad_busy, bad_rdy;
    rst_n = 1'b0;
    drive(3'b000, 7'h00, 8'h00, 1'b0);

    //                btn     sw     rxd    rxv  we   addr     data   x      y
    vt[0]  = '{3'b000, 7'h00, 8'h41, 1'b1, 1'b1, 12'h000, 7'h41, 7'd1,  5'd0};
    vt[1]  = '{3'b000, 7'h00, 8'h42, 1'b1, 1'b1, 12'h001, 7'h42, 7'd2,  5'd0};
    vt[2]  = '{3'b000, 7'h00, 8'h00, 1'b0, 1'b0, 12'h000, 7'h00, 7'd2,  5'd0};
    vt[3]  = '{3'b001, 7'h33, 8'h00, 1'b0, 1'b1, 12'h002, 7'h33, 7'd3,  5'd0};
    vt[4]  = '{3'b010, 7'h00, 8'h00, 1'b0, 1'b0, 12'h000, 7'h00, 7'd4,  5'd0};
    vt[5]  = '{3'b000, 7'h00, 8'hC5, 1'b1, 1'b1, 12'h004, 7'h45, 7'd5,  5'd0};
    vt[6]  = '{3'b000, 7'h00, 8'h0A, 1'b1, 1'b0, 12'h000, 7'h00, 7'd5,  5'd1};
    vt[7]  = '{3'b000, 7'h00, 8'h0D, 1'b1, 1'b0, 12'h000, 7'h00, 7'd0,  5'd1};
    vt[8]  = '{3'b000, 7'h00, 8'h08, 1'b1, 1'b1, 12'h04F, 7'h00, 7'd79, 5'd0};
    vt[9]  = '{3'b000, 7'h00, 8'h5A, 1'b1, 1'b1, 12'h04F, 7'h5A, 7'd0,  5'd1};
    vt[10] = '{3'b011, 7'h77, 8'h51, 1'b1, 1'b1, 12'h080, 7'h51, 7'd1,  5'd1};
    vt[11] = '{3'b000, 7'h00, 8'h08, 1'b1, 1'b1, 12'h080, 7'h00, 7'd0,  5'd1};
    vt[12] = '{3'b000, 7'h00, 8'h08, 1'b1, 1'b1, 12'h04F, 7'h00, 7'd79, 5'd0};

    // Reset state
    step();
    check("reset we",       32'(we),       32'd0);
    check("reset waddr",    32'(waddr),    32'd0);
    check("reset wdata",    32'(wdata),    32'd0);
    check("reset cur_x",    32'(cur_x),    32'd0);
    check("reset cur_y",    32'(cur_y),    32'd0);
    check("reset busy",     32'(busy),     32'd0);
    check("reset rx_ready", 32'(rx_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Vector table
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].btn, vt[i].sw, vt[i].rxd, vt[i].rxv);
      step();
      check($sformatf("vec%0d we", i), 32'(we), 32'(vt[i].we));
      if (vt[i].we) begin
        check($sformatf("vec%0d waddr", i), 32'(waddr), 32'(vt[i].addr));
        check($sformatf("vec%0d wdata", i), 32'(wdata), 32'(vt[i].data));
      end
      check($sformatf("vec%0d cur_x", i), 32'(cur_x), 32'(vt[i].x));
      check($sformatf("vec%0d cur_y", i), 32'(cur_y), 32'(vt[i].y));
    end
    drive(3'b000, 7'h00, 8'h00, 1'b0);

    // Screen wraps around (0,0) and (79,29)
    do_reset();
    ev("bs00",   3'b000, 8'h08, 1'b1, 1'b1, 12'hECF, 7'h00, 7'd79, 5'd29);
    ev("right",  3'b010, 8'h00, 1'b0, 1'b0, 12'h000, 7'h00, 7'd0,  5'd0);
    ev("bs00b",  3'b000, 8'h08, 1'b1, 1'b1, 12'hECF, 7'h00, 7'd79, 5'd29);
    ev("lfwrap", 3'b000, 8'h0A, 1'b1, 1'b0, 12'h000, 7'h00, 7'd79, 5'd0);

    // Move to (5,3) then CR, BS, LF
    do_reset();
    bad_we = 0;
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, 7'h00, 8'h0A, 1'b1);
      step();
      if (we) bad_we++;
    end
    for (int i = 0; i < 5; i++) begin
      drive(3'b010, 7'h00, 8'h00, 1'b0);
      step();
      if (we) bad_we++;
    end
    check("move nowrite", 32'(bad_we), 32'd0);
    ev("cr", 3'b000, 8'h0D, 1'b1, 1'b0, 12'h000, 7'h00, 7'd0,  5'd3);
    ev("bs", 3'b000, 8'h08, 1'b1, 1'b1, 12'h14F, 7'h00, 7'd79, 5'd2);
    ev("lf", 3'b000, 8'h0A, 1'b1, 1'b0, 12'h000, 7'h00, 7'd79, 5'd3);

    // Clear with a UART byte held pending
    drive(3'b100, 7'h00, 8'h48, 1'b1);
    #1;
    check("clr N rx_ready", 32'(rx_ready), 32'd0);
    step();
    btn_pulse = 3'b000;
    check("clr cur_x", 32'(cur_x), 32'd0);
    check("clr cur_y", 32'(cur_y), 32'd0);
    ex = 0;
    ey = 0;
    bad_busy = 0;
    bad_rdy = 0;
    bad_we = 0;
    for (int i = 0; i < 2400; i++) begin
      if (!busy) bad_busy++;
      if (rx_ready) bad_rdy++;
      if (!we || wdata != 7'h00) bad_we++;
      check($sformatf("clr addr%0d", i), 32'(waddr), 32'({ey[4:0], ex[6:0]}));
      ex++;
      if (ex == 80) begin
        ex = 0;
        ey++;
      end
      step();
    end
    check("clr busy high", 32'(bad_busy), 32'd0);
    check("clr rx_ready low", 32'(bad_rdy), 32'd0);
    check("clr writes", 32'(bad_we), 32'd0);
    check("clr end busy", 32'(busy), 32'd0);
    check("clr end we", 32'(we), 32'd0);
    check("clr end rx_ready", 32'(rx_ready), 32'd1);
    step();
    drive(3'b000, 7'h00, 8'h00, 1'b0);
    check("held we", 32'(we), 32'd1);
    check("held waddr", 32'(waddr), 32'h000);
    check("held wdata", 32'(wdata), 32'h48);
    check("held cur_x", 32'(cur_x), 32'd1);

    // Reset during a clear, after 1000 writes
    step();
    drive(3'b100, 7'h00, 8'h00, 1'b0);
    step();
    drive(3'b000, 7'h00, 8'h00, 1'b0);
    for (int i = 1; i < 1000; i++) step();
    check("mid clr addr", 32'(waddr), 32'd999 - 32'd80 * 32'd12 + (32'd12 << 7));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst we",       32'(we),       32'd0);
    check("midrst waddr",    32'(waddr),    32'd0);
    check("midrst wdata",    32'(wdata),    32'd0);
    check("midrst cur_x",    32'(cur_x),    32'd0);
    check("midrst cur_y",    32'(cur_y),    32'd0);
    check("midrst busy",     32'(busy),     32'd0);
    check("midrst rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad_we = 0;
    bad_busy = 0;
    bad_rdy = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (we) bad_we++;
      if (busy) bad_busy++;
      if (!rx_ready) bad_rdy++;
    end
    check("post rst no writes", 32'(bad_we), 32'd0);
    check("post rst busy", 32'(bad_busy), 32'd0);
    check("post rst rx_ready", 32'(bad_rdy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
